nabp_processing_swap_control: RTL
=================================

NABP_PROCESSING_SWAP_CONTROL -- requirements
Module: nabp_processing_swap_control

Interface
REQ-001 SHALL have parameter N_ANGLES, default 180, number of projection iterations per run (1..255).
REQ-002 SHALL have parameter ACC_W, default 16, width of all accumulator base/step values.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports start in 1 (run kick pulse); busy out 1 (run in progress); done out 1 (run-complete pulse).
REQ-006 SHALL have ports cfg_sh_init, cfg_sh_step, cfg_mp_init, cfg_mp_init_step, cfg_mp_step  in  ACC_W each  per-run accumulator seeds; sampled at accepted start.
REQ-007 SHALL have, per unit u in {0,1}: sw_next_itr_u in 1 (unit ready for next iteration); sw_next_itr_ack_u out 1; sw_swap_u in 1 (unit fill done, requests swap); sw_swap_ack_u out 1; sh_shift_done_u in 1 (unit iteration complete pulse).
REQ-008 SHALL have shared outputs sw_sh_accu_base, sw_mp_accu_init, sw_mp_accu_base  out  ACC_W each  values for the iteration being granted.

Function
REQ-009 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN when iteration index k reaches N_ANGLES, DRAIN->IDLE when outstanding count is 0.
REQ-010 SHALL ignore start while not in IDLE.
REQ-011 SHALL on accepted start load k=0, sh_acc=cfg_sh_init, mpi_acc=cfg_mp_init, mp_acc=0, rr pointer=unit 0, outstanding=0, order queue empty.
REQ-012 SHALL drive sw_sh_accu_base=sh_acc, sw_mp_accu_init=mpi_acc, sw_mp_accu_base=mp_acc directly from registers, stable during any ack cycle.
REQ-013 SHALL assert sw_next_itr_ack_u combinationally, same cycle as sw_next_itr_u, only in RUN, at most one unit per cycle.
REQ-014 SHALL resolve simultaneous next_itr requests by rr pointer; pointer moves to the other unit after every next_itr grant.
REQ-015 SHALL on each next_itr grant: k+=1, sh_acc+=cfg_sh_step, mpi_acc+=cfg_mp_init_step, mp_acc+=cfg_mp_step (modulo 2^ACC_W, wrap silently), outstanding+=1, push unit id into 2-entry order queue.
REQ-016 SHALL assert sw_swap_ack_u combinationally only when sw_swap_u is high and u is at the order-queue head; pop head on that cycle (swaps occur in grant order).
REQ-017 SHALL never assert both sw_swap_ack_0 and sw_swap_ack_1 in one cycle.
REQ-018 SHALL decrement outstanding on each sh_shift_done_u pulse; simultaneous done from both units decrements by 2; grant and done in same cycle net correctly.
REQ-019 SHALL pulse done for exactly one cycle on the DRAIN->IDLE transition; busy high in RUN and DRAIN.
REQ-020 SHALL issue exactly N_ANGLES next_itr grants per run; no grant in DRAIN or IDLE.

Reset
REQ-021 SHALL on reset assertion immediately force IDLE, all acks, busy, done low, k, accumulators, outstanding, rr pointer to 0, queue empty, regardless of operation in progress.
REQ-022 SHALL require a new start after reset release; no run resumes.

Verification
REQ-023 Single unit: N_ANGLES=3, cfg_sh_init=10, cfg_sh_step=4, only unit 0 requests -> acks with sw_sh_accu_base 10,14,18; done one cycle after third sh_shift_done_0.
REQ-024 Contention: both units request same cycle after start -> ack_0 first with k=0 values, ack_1 next cycle with k=1 values.
REQ-025 Ordering: unit 1 granted after unit 0 but raises sw_swap first -> no sw_swap_ack_1 until sw_swap_ack_0 issued.
REQ-026 Wrap: ACC_W=16, cfg_mp_step=0xC000, 3 grants -> sw_mp_accu_base 0x0000, 0xC000, 0x8000.
REQ-027 Reset mid-run after 2 grants -> all outputs 0 same cycle; start again -> first grant shows cfg_sh_init.
REQ-028 Start pulsed during RUN -> ignored; grant count stays N_ANGLES.

Source files
------------

// File: rtl/nabp_processing_swap_control.sv
// Run sequencer for two back-projection units: hands out N_ANGLES iterations with their
// accumulator bases, keeps buffer swaps in grant order and tracks iterations still shifting.
module nabp_processing_swap_control #(
    parameter int N_ANGLES = 180,
    parameter int ACC_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state,
    input  logic [ACC_W-1:0] cfg_sh_init,
    input  logic [ACC_W-1:0] cfg_sh_step,
    input  logic [ACC_W-1:0] cfg_mp_init,
    input  logic [ACC_W-1:0] cfg_mp_init_step,
    input  logic [ACC_W-1:0] cfg_mp_step,
    input  logic             sw_next_itr_0,
    output logic             sw_next_itr_ack_0,
    input  logic             sw_swap_0,
    output logic             sw_swap_ack_0,
    input  logic             sh_shift_done_0,
    input  logic             sw_next_itr_1,
    output logic             sw_next_itr_ack_1,
    input  logic             sw_swap_1,
    output logic             sw_swap_ack_1,
    input  logic             sh_shift_done_1,
    output logic [ACC_W-1:0] sw_sh_accu_base,
    output logic [ACC_W-1:0] sw_mp_accu_init,
    output logic [ACC_W-1:0] sw_mp_accu_base
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] K_LAST = 8'(N_ANGLES);

    state_t           state_q, state_d;
    logic [7:0]       k_q, k_d;
    logic [ACC_W-1:0] sh_acc_q, sh_acc_d;
    logic [ACC_W-1:0] mpi_acc_q, mpi_acc_d;
    logic [ACC_W-1:0] mp_acc_q, mp_acc_d;
    logic [ACC_W-1:0] sh_step_q, sh_step_d;
    logic [ACC_W-1:0] mpi_step_q, mpi_step_d;
    logic [ACC_W-1:0] mp_step_q, mp_step_d;
    logic             rr_q, rr_d;
    logic [8:0]       out_q, out_d;
    logic             q0_q, q0_d;
    logic             q1_q, q1_d;
    logic [1:0]       qcnt_q, qcnt_d;
    logic             done_q, done_d;

    logic can_grant, gnt0, gnt1, granted, gnt_id;
    logic swap0, swap1, popped;

    // Grants stall while both swap-order slots are occupied so no swap is ever lost.
    always_comb begin
        can_grant = (state_q == S_RUN) && (qcnt_q != 2'd2);
        gnt0      = can_grant && sw_next_itr_0 && (!sw_next_itr_1 || !rr_q);
        gnt1      = can_grant && sw_next_itr_1 && (!sw_next_itr_0 || rr_q);
        granted   = gnt0 || gnt1;
        gnt_id    = gnt1;
        swap0     = (qcnt_q != 2'd0) && !q0_q && sw_swap_0;
        swap1     = (qcnt_q != 2'd0) && q0_q && sw_swap_1;
        popped    = swap0 || swap1;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        sh_acc_d   = sh_acc_q;
        mpi_acc_d  = mpi_acc_q;
        mp_acc_d   = mp_acc_q;
        sh_step_d  = sh_step_q;
        mpi_step_d = mpi_step_q;
        mp_step_d  = mp_step_q;
        rr_d       = rr_q;
        out_d      = out_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        qcnt_d     = qcnt_q;
        done_d     = 1'b0;

        if (granted) begin
            k_d       = k_q + 8'd1;
            sh_acc_d  = sh_acc_q + sh_step_q;
            mpi_acc_d = mpi_acc_q + mpi_step_q;
            mp_acc_d  = mp_acc_q + mp_step_q;
            rr_d      = !gnt_id;
        end

        if (granted && popped) begin
            q0_d = (qcnt_q == 2'd1) ? gnt_id : q1_q;
        end else if (granted) begin
            if (qcnt_q == 2'd0) q0_d = gnt_id;
            else                q1_d = gnt_id;
            qcnt_d = qcnt_q + 2'd1;
        end else if (popped) begin
            q0_d   = q1_q;
            qcnt_d = qcnt_q - 2'd1;
        end

        if (state_q != S_IDLE) begin
            out_d = out_q + {8'd0, granted} - {8'd0, sh_shift_done_0} - {8'd0, sh_shift_done_1};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    k_d        = 8'd0;
                    sh_acc_d   = cfg_sh_init;
                    mpi_acc_d  = cfg_mp_init;
                    mp_acc_d   = '0;
                    sh_step_d  = cfg_sh_step;
                    mpi_step_d = cfg_mp_init_step;
                    mp_step_d  = cfg_mp_step;
                    rr_d       = 1'b0;
                    out_d      = 9'd0;
                    qcnt_d     = 2'd0;
                    q0_d       = 1'b0;
                    q1_d       = 1'b0;
                end
            end
            S_RUN: begin
                if (k_d == K_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Looking at the next count makes done follow the last shift-done by one cycle.
                if (out_d == 9'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= 8'd0;
            sh_acc_q   <= '0;
            mpi_acc_q  <= '0;
            mp_acc_q   <= '0;
            sh_step_q  <= '0;
            mpi_step_q <= '0;
            mp_step_q  <= '0;
            rr_q       <= 1'b0;
            out_q      <= 9'd0;
            q0_q       <= 1'b0;
            q1_q       <= 1'b0;
            qcnt_q     <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            sh_acc_q   <= sh_acc_d;
            mpi_acc_q  <= mpi_acc_d;
            mp_acc_q   <= mp_acc_d;
            sh_step_q  <= sh_step_d;
            mpi_step_q <= mpi_step_d;
            mp_step_q  <= mp_step_d;
            rr_q       <= rr_d;
            out_q      <= out_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            qcnt_q     <= qcnt_d;
            done_q     <= done_d;
        end
    end

    // Handshake: each ack is high only in the same cycle as its request and means accepted.
    assign sw_next_itr_ack_0 = gnt0;
    assign sw_next_itr_ack_1 = gnt1;
    assign sw_swap_ack_0     = swap0;
    assign sw_swap_ack_1     = swap1;
    assign sw_sh_accu_base   = sh_acc_q;
    assign sw_mp_accu_init   = mpi_acc_q;
    assign sw_mp_accu_base   = mp_acc_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign dbg_state         = state_q;

endmodule
